// File: rtl/resp_collector.sv
// Sensor response return path: round-robin pick of one pending sensor response,
// serialised to the UART transmitter as a 3-byte frame {addr, code, value}.
module resp_collector #(
  parameter int NUM_SENSORS = 32,
  parameter int ADDR_W      = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_SENSORS-1:0]   resp_valid,
  input  logic [8*NUM_SENSORS-1:0] resp_code,
  input  logic [8*NUM_SENSORS-1:0] resp_value,
  output logic [NUM_SENSORS-1:0]   resp_ack,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic                     frame_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      ptr_q, ptr_d;
  logic [ADDR_W-1:0]      cap_addr_q, cap_addr_d;
  logic [7:0]             cap_code_q, cap_code_d;
  logic [7:0]             cap_value_q, cap_value_d;
  logic [1:0]             byte_idx_q, byte_idx_d;
  logic [NUM_SENSORS-1:0] ack_d;
  logic                   tx_start_d;
  logic [7:0]             tx_data_d;
  logic                   frame_busy_d;

  logic                   found;
  logic [ADDR_W-1:0]      win_idx;
  logic [ADDR_W-1:0]      cand;
  logic [7:0]             win_code;
  logic [7:0]             win_value;
  logic [7:0]             cur_byte;

  // Round-robin search: walk from ptr+1 around the ring, first pending sensor wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = ptr_q;
    for (int k = 0; k < NUM_SENSORS; k++) begin
      cand = (cand == ADDR_W'(NUM_SENSORS - 1)) ? '0 : cand + ADDR_W'(1);
      if (!found && resp_valid[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    win_code  = '0;
    win_value = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (win_idx == ADDR_W'(i)) begin
        win_code  = resp_code[8*i +: 8];
        win_value = resp_value[8*i +: 8];
      end
    end
  end

  always_comb begin
    case (byte_idx_q)
      2'd0:    cur_byte = 8'(cap_addr_q);
      2'd1:    cur_byte = cap_code_q;
      default: cur_byte = cap_value_q;
    endcase
  end

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cap_addr_d   = cap_addr_q;
    cap_code_d   = cap_code_q;
    cap_value_d  = cap_value_q;
    byte_idx_d   = byte_idx_q;
    ack_d        = '0;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data;
    frame_busy_d = frame_busy;

    case (state_q)
      IDLE: begin
        if (found) begin
          cap_addr_d     = win_idx;
          cap_code_d     = win_code;
          cap_value_d    = win_value;
          ptr_d          = win_idx;
          ack_d[win_idx] = 1'b1;
          byte_idx_d     = 2'd0;
          frame_busy_d   = 1'b1;
          state_d        = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = cur_byte;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (tx_done) begin
          if (byte_idx_q < 2'd2) begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = SEND;
          end else begin
            frame_busy_d = 1'b0;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pointer starts at the last sensor so the first search after reset begins at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= ADDR_W'(NUM_SENSORS - 1);
      cap_addr_q  <= '0;
      cap_code_q  <= '0;
      cap_value_q <= '0;
      byte_idx_q  <= '0;
      resp_ack    <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      frame_busy  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      cap_addr_q  <= cap_addr_d;
      cap_code_q  <= cap_code_d;
      cap_value_q <= cap_value_d;
      byte_idx_q  <= byte_idx_d;
      resp_ack    <= ack_d;
      tx_start    <= tx_start_d;
      tx_data     <= tx_data_d;
      frame_busy  <= frame_busy_d;
    end
  end

endmodule

// File: tb/tb_resp_collector.sv
// Directed bench for resp_collector with a 10-cycle UART TX model and
// sensors that drop their request after being acknowledged.
module tb_resp_collector;

  localparam int NS = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NS-1:0]   resp_valid;
  logic [8*NS-1:0] resp_code;
  logic [8*NS-1:0] resp_value;
  logic [NS-1:0]   resp_ack;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic            tx_done;
  logic            frame_busy;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] start_q[$];
  int         ack_q[$];
  int         start_base = 0;
  int         ack_base = 0;
  int         ack_err = 0;
  int         done_seen = 0;
  logic       hold_busy = 1'b0;
  logic       inj_done = 1'b0;
  logic [NS-1:0] keep = '0;

  resp_collector #(.NUM_SENSORS(NS), .ADDR_W(5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .resp_valid (resp_valid),
    .resp_code  (resp_code),
    .resp_value (resp_value),
    .resp_ack   (resp_ack),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .frame_busy (frame_busy)
  );

  always #5 clk = ~clk;

  // UART TX model plus ack/start monitor, evaluated just after each rising edge.
  initial begin : tx_model
    int   tx_cnt;
    logic model_done;
    logic fb_prev;
    int   idx;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    tx_cnt  = 0;
    fb_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        tx_cnt  = 0;
        tx_done = 1'b0;
        tx_busy = hold_busy;
        fb_prev = 1'b0;
      end else begin
        if (resp_ack != '0) begin
          idx = -1;
          for (int i = 0; i < NS; i++) if (resp_ack[i]) idx = i;
          ack_q.push_back(idx);
          if ($countones(resp_ack) != 1) ack_err++;
          if (fb_prev) ack_err++;
        end
        fb_prev    = frame_busy;
        model_done = 1'b0;
        if (tx_cnt > 0) begin
          tx_cnt--;
          if (tx_cnt == 0) model_done = 1'b1;
        end
        if (tx_start) begin
          start_q.push_back(tx_data);
          tx_cnt = 10;
        end
        tx_done = model_done | inj_done;
        tx_busy = (tx_cnt > 0) | hold_busy;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // One cycle; sensors not marked 'keep' drop their request once acknowledged.
  task automatic stepCycle();
    @(negedge clk);
    if (tx_done) done_seen++;
    for (int i = 0; i < NS; i++) begin
      if (resp_ack[i] && !keep[i]) resp_valid[i] = 1'b0;
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] code, input logic [7:0] value,
                               input logic keep_req);
    resp_code[8*idx +: 8]  = code;
    resp_value[8*idx +: 8] = value;
    keep[idx]              = keep_req;
    resp_valid[idx]        = 1'b1;
  endtask

  task automatic markLogs();
    start_base = start_q.size();
    ack_base   = ack_q.size();
    done_seen  = 0;
  endtask

  function automatic int startAt(input int i);
    if (start_base + i < start_q.size()) return int'(start_q[start_base + i]);
    return -1;
  endfunction

  function automatic int ackAt(input int i);
    if (ack_base + i < ack_q.size()) return ack_q[ack_base + i];
    return -1;
  endfunction

  task automatic waitStarts(input int n, input int budget, input string tag);
    int k = 0;
    while ((start_q.size() - start_base) < n && k < budget) begin
      stepCycle();
      k++;
    end
    checkOutput(tag, start_q.size() - start_base, n);
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int k = 0;
    while (frame_busy && k < budget) begin
      stepCycle();
      k++;
    end
    checkOutput(tag, int'(frame_busy), 0);
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    repeat (3) stepCycle();
    reset_n = 1'b1;
  endtask

  initial begin : main
    int k;
    reset_n    = 1'b0;
    resp_valid = '0;
    resp_code  = '0;
    resp_value = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ack", int'(resp_ack), 0);
    checkOutput("rst_tx_start", int'(tx_start), 0);
    checkOutput("rst_tx_data", int'(tx_data), 0);
    checkOutput("rst_frame_busy", int'(frame_busy), 0);
    reset_n = 1'b1;
    repeat (2) stepCycle();
    checkOutput("idle_no_start", int'(tx_start), 0);

    // Single request from sensor 3; source data changes after capture.
    markLogs();
    applyStimulus(3, 8'h41, 8'h1C, 1'b0);
    stepCycle();
    checkOutput("t1_ack", int'(resp_ack), 32'h0000_0008);
    checkOutput("t1_busy_up", int'(frame_busy), 1);
    resp_code[31:24]  = 8'hFF;
    resp_value[31:24] = 8'hEE;
    stepCycle();
    checkOutput("t1_first_start", int'(tx_start), 1);
    checkOutput("t1_first_data", int'(tx_data), 8'h03);
    k = 0;
    while (done_seen < 3 && k < 200) begin
      stepCycle();
      k++;
    end
    checkOutput("t1_done_cnt", done_seen, 3);
    checkOutput("t1_busy_at_done", int'(frame_busy), 1);
    stepCycle();
    checkOutput("t1_busy_fall", int'(frame_busy), 0);
    repeat (5) stepCycle();
    checkOutput("t1_nstarts", start_q.size() - start_base, 3);
    checkOutput("t1_b0", startAt(0), 8'h03);
    checkOutput("t1_b1", startAt(1), 8'h41);
    checkOutput("t1_b2", startAt(2), 8'h1C);
    checkOutput("t1_nacks", ack_q.size() - ack_base, 1);
    checkOutput("t1_ack_idx", ackAt(0), 3);

    // Simultaneous requests on 0, 5 and 31 right after reset.
    applyReset();
    markLogs();
    applyStimulus(0, 8'h10, 8'h80, 1'b0);
    applyStimulus(5, 8'h15, 8'h85, 1'b0);
    applyStimulus(31, 8'h1F, 8'h9F, 1'b0);
    waitStarts(9, 400, "t2_starts");
    waitIdle(100, "t2_idle");
    checkOutput("t2_f0_addr", startAt(0), 8'h00);
    checkOutput("t2_f0_code", startAt(1), 8'h10);
    checkOutput("t2_f0_val", startAt(2), 8'h80);
    checkOutput("t2_f1_addr", startAt(3), 8'h05);
    checkOutput("t2_f1_code", startAt(4), 8'h15);
    checkOutput("t2_f2_addr", startAt(6), 8'h1F);
    checkOutput("t2_f2_val", startAt(8), 8'h9F);
    checkOutput("t2_ack0", ackAt(0), 0);
    checkOutput("t2_ack1", ackAt(1), 5);
    checkOutput("t2_ack2", ackAt(2), 31);

    // Round-robin fairness between two sensors that never stop requesting.
    markLogs();
    applyStimulus(2, 8'h22, 8'h23, 1'b1);
    applyStimulus(4, 8'h44, 8'h45, 1'b1);
    waitStarts(24, 1500, "t3_starts");
    keep[2] = 1'b0;
    keep[4] = 1'b0;
    resp_valid[2] = 1'b0;
    resp_valid[4] = 1'b0;
    waitIdle(100, "t3_idle");
    for (int f = 0; f < 8; f++) begin
      checkOutput($sformatf("t3_frame%0d_addr", f), startAt(3*f), (f % 2 == 0) ? 2 : 4);
    end
    checkOutput("t3_f1_code", startAt(4), 8'h44);
    checkOutput("t3_nacks", ack_q.size() - ack_base, 8);

    // tx_busy stall in SEND, with a spurious tx_done during the stall.
    markLogs();
    hold_busy = 1'b1;
    stepCycle();
    applyStimulus(9, 8'h55, 8'h66, 1'b0);
    stepCycle();
    checkOutput("t4_busy_up", int'(frame_busy), 1);
    for (int i = 0; i < 20; i++) begin
      inj_done = (i == 5);
      stepCycle();
    end
    inj_done = 1'b0;
    checkOutput("t4_no_start", start_q.size() - start_base, 0);
    hold_busy = 1'b0;
    stepCycle();
    checkOutput("t4_start_wait", int'(tx_start), 0);
    stepCycle();
    checkOutput("t4_start", int'(tx_start), 1);
    checkOutput("t4_data", int'(tx_data), 8'h09);
    waitStarts(3, 200, "t4_starts");
    waitIdle(100, "t4_idle");
    checkOutput("t4_b1", startAt(1), 8'h55);
    checkOutput("t4_b2", startAt(2), 8'h66);

    // Spurious tx_done while idle.
    markLogs();
    inj_done = 1'b1;
    stepCycle();
    inj_done = 1'b0;
    repeat (4) stepCycle();
    checkOutput("t6_idle_no_start", start_q.size() - start_base, 0);
    checkOutput("t6_idle_busy", int'(frame_busy), 0);

    // Reset in the middle of a frame; sensor 7 keeps requesting.
    markLogs();
    applyStimulus(7, 8'h77, 8'h78, 1'b1);
    waitStarts(2, 200, "t5_pre_starts");
    checkOutput("t5_pre_data", int'(tx_data), 8'h77);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t5_rst_ack", int'(resp_ack), 0);
    checkOutput("t5_rst_start", int'(tx_start), 0);
    checkOutput("t5_rst_data", int'(tx_data), 0);
    checkOutput("t5_rst_busy", int'(frame_busy), 0);
    repeat (2) stepCycle();
    markLogs();
    reset_n = 1'b1;
    waitStarts(3, 200, "t5_starts");
    keep[7] = 1'b0;
    resp_valid[7] = 1'b0;
    waitIdle(100, "t5_idle");
    checkOutput("t5_b0", startAt(0), 8'h07);
    checkOutput("t5_b1", startAt(1), 8'h77);
    checkOutput("t5_b2", startAt(2), 8'h78);

    checkOutput("ack_protocol", ack_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/resp_collector.md
# resp_collector

Return path of the sensor subsystem. It collects responses from up to 32 sensing modules and serialises them to the UART transmitter as 3-byte frames, one frame per response. When several sensing modules have a response pending at once, it picks one by round-robin. It is the counterpart of the address dispatcher that fans UART RX commands out to the sensing modules.

## Interface
- `NUM_SENSORS`, default 32: number of sensing modules; valid range 2..32.
- `ADDR_W`, default 5: width of the sensor index.
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `resp_valid`  in  NUM_SENSORS  bit i high means module i has a response pending. The module holds it high until it sees `resp_ack[i]`.
- `resp_code`  in  8*NUM_SENSORS  response code; module i drives bits [8i+7:8i].
- `resp_value`  in  8*NUM_SENSORS  response data; module i drives bits [8i+7:8i].
- `resp_ack`  out  NUM_SENSORS  registered one-hot pulse, one cycle, on the winning module.
- `tx_start`  out  1  registered one-cycle pulse that starts a UART TX byte.
- `tx_data`  out  8  byte to send; stable from `tx_start` until the matching `tx_done`.
- `tx_busy`  in  1  UART TX is shifting.
- `tx_done`  in  1  one-cycle pulse when UART TX finishes a byte.
- `frame_busy`  out  1  high from capture until the last `tx_done` of the frame.

## Operation
- **Frame format**, in order:
  - byte0 = {3'b000, addr}
  - byte1 = code
  - byte2 = value
- **FSM states:** IDLE, SEND, WAIT.
- **IDLE**
  - Round-robin search of `resp_valid` starts at `ptr+1` and wraps modulo `NUM_SENSORS`. The first set bit wins.
  - On a clock edge with any valid bit set:
    - capture the winner's addr, code and value into internal registers;
    - set `ptr` to the winner;
    - pulse `resp_ack[winner]` for one cycle;
    - set byte index to 0 and `frame_busy` to 1;
    - go to SEND.
- **SEND**
  - While `tx_busy` = 1, hold the state.
  - When `tx_busy` = 0, pulse `tx_start` for one cycle, drive `tx_data` with the current byte, and go to WAIT.
- **WAIT**
  - On `tx_done`:
    - if byte index < 2, increment it and go to SEND;
    - if byte index = 2, clear `frame_busy` and go to IDLE.
  - `tx_done` is ignored in IDLE and SEND.
- **Data ownership:** captured data is frame-owned. Changes on `resp_code`/`resp_value` or on `resp_valid` after capture do not affect the frame in flight.
- **Arbitration:** new requests are only sampled in IDLE. `resp_valid` bits of modules that are not acknowledged stay pending.
- **Index range:** index bits ≥ `NUM_SENSORS` cannot exist. Unused `resp_valid` inputs are ignored.

## Timing
- **Reset values:** state IDLE; `ptr` = `NUM_SENSORS`-1, so the first search starts at 0. `resp_ack` = 0, `tx_start` = 0, `tx_data` = 0x00, `frame_busy` = 0, byte index = 0.
- **Capture latency:** `resp_valid[i]` rising before edge N, with state IDLE, gives `resp_ack[i]` and `frame_busy` high after edge N.
- **First byte latency:** with `tx_busy` low, `tx_start` for byte0 is high after edge N+1.
- **Between bytes:** a `tx_done` sampled at edge M gives the next `tx_start` after edge M+1 at the earliest, i.e. one cycle gap.
- **Back-to-back frames:** the final `tx_done` at edge M returns the FSM to IDLE after M. The next capture can happen at edge M+1.
- **Ack / valid handshake:** `resp_ack` is never asserted on two bits at once, and never while `frame_busy` is already high. The sensing module drops `resp_valid` the cycle after `resp_ack`. Because the FSM is out of IDLE during that cycle, there is no double capture.
- **Reset mid-frame:** all outputs return to their reset values immediately, asynchronously. The partial frame is abandoned and pending `resp_valid` bits are served after release.
- **Reset release:** `reset_n` is deasserted synchronously with respect to the FSM. There is no first-cycle activity other than IDLE evaluation.

## Test plan
- **Single request:** `resp_valid[3]`=1, code=0x41, value=0x1C, TX model has a 10-cycle byte time. Expect:
  - exactly one `resp_ack[3]` pulse;
  - `tx_data` sequence 0x03, 0x41, 0x1C;
  - three `tx_start` pulses;
  - `frame_busy` falls one cycle after the third `tx_done`.
- **Simultaneous requests:** `resp_valid[0]`, `[5]` and `[31]` set in the same cycle after reset. Expect frames in order addr 0x00, 0x05, 0x1F, and three acks in that order.
- **Round-robin fairness:** modules 2 and 4 both keep requesting continuously. Expect frames alternating 0x02, 0x04, 0x02, 0x04, with no starvation over 8 frames.
- **tx_busy stall:** hold `tx_busy`=1 for 20 cycles during SEND. Expect no `tx_start` until `tx_busy` falls, then `tx_start` the next cycle with `tx_data` unchanged.
- **Mid-frame reset:** assert `reset_n`=0 after the byte1 `tx_start`. Expect outputs 0 immediately. After release, with `resp_valid[7]` still high, expect a fresh frame starting with 0x07.
- **Spurious tx_done:** `tx_done` pulses in IDLE and in SEND. Expect no state change and no extra `tx_start`.
